// File: rtl/iob_bus_merge.sv
`default_nettype none
// ============================================================================
// Module   : iob_bus_merge
// Brief    : Merges N IOb managers onto one subordinate, round-robin with
//            grant lock on stall and in-order read-response routing.
//            Define IOB_BUS_MERGE_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module iob_bus_merge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N       = 2,
  parameter int NB      = $clog2(N),
  parameter int MAX_OUT = 4
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     rst_n_i,
  input  logic [N-1:0]             m_valid_i,
  input  logic [N*ADDR_W-1:0]      m_addr_i,
  input  logic [N*DATA_W-1:0]      m_wdata_i,
  input  logic [N*(DATA_W/8)-1:0]  m_wstrb_i,
  output logic [N*DATA_W-1:0]      m_rdata_o,
  output logic [N-1:0]             m_rvalid_o,
  output logic [N-1:0]             m_ready_o,
  output logic                     s_valid_o,
  output logic [ADDR_W-1:0]        s_addr_o,
  output logic [DATA_W-1:0]        s_wdata_o,
  output logic [DATA_W/8-1:0]      s_wstrb_o,
  input  logic [DATA_W-1:0]        s_rdata_i,
  input  logic                     s_rvalid_i,
  input  logic                     s_ready_i,
  output logic                     rsp_err_o
);

  localparam int SW = DATA_W / 8;
  localparam int AW = $clog2(MAX_OUT);
  localparam int CW = AW + 1;

`ifdef IOB_BUS_MERGE_FIXED_PRIO_EN
  localparam int c_start = 0;
`else
  logic [NB-1:0] r_ptr;
`endif

  logic          r_lock;
  logic [NB-1:0] r_lgnt;
  logic [NB-1:0] r_fifo [MAX_OUT];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rsp_err;

  int            w_start;
  int            w_idx;
  logic          w_found;
  logic [NB-1:0] w_gnt;
  logic [NB-1:0] w_sel;
  logic          w_have;
  logic          w_req;
  logic [SW-1:0] w_strb;
  logic          w_is_read;
  logic          w_block;
  logic          w_accept;
  logic          w_push;
  logic          w_stall;
  logic          w_pop;
  logic          w_stray;

`ifdef IOB_BUS_MERGE_FIXED_PRIO_EN
  assign w_start = c_start;
`else
  assign w_start = int'(r_ptr);
`endif

  // Search for the first requester starting at w_start, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (w_start + k) % N;
      if (!w_found && m_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = NB'(w_idx);
      end
    end
  end

  assign w_sel     = r_lock ? r_lgnt : w_gnt;
  assign w_have    = r_lock | w_found;
  assign w_req     = w_have & m_valid_i[w_sel];
  assign w_strb    = m_wstrb_i[int'(w_sel)*SW +: SW];
  assign w_is_read = (w_strb == '0);
  // Full check uses the pre-cycle count so a same-cycle pop cannot unblock.
  assign w_block   = w_is_read & (r_count == CW'(MAX_OUT));

  assign s_valid_o = rst_n_i & w_req & ~w_block;
  assign s_addr_o  = m_addr_i[int'(w_sel)*ADDR_W +: ADDR_W];
  assign s_wdata_o = m_wdata_i[int'(w_sel)*DATA_W +: DATA_W];
  assign s_wstrb_o = w_strb;

  assign w_accept = s_valid_o & s_ready_i;
  assign w_push   = w_accept & w_is_read;
  assign w_stall  = s_valid_o & ~s_ready_i;
  assign w_pop    = rst_n_i & s_rvalid_i & (r_count != '0);
  assign w_stray  = rst_n_i & s_rvalid_i & (r_count == '0);

  always_comb begin
    m_ready_o = '0;
    if (rst_n_i && w_have && s_ready_i && !w_block) begin
      m_ready_o[w_sel] = 1'b1;
    end
  end

  always_comb begin
    m_rvalid_o = '0;
    if (w_pop) begin
      m_rvalid_o[r_fifo[r_rptr]] = 1'b1;
    end
  end

  assign m_rdata_o = {N{s_rdata_i}};
  assign rsp_err_o = r_rsp_err;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
`ifdef IOB_BUS_MERGE_FIXED_PRIO_EN
`else
        r_ptr     <= '0;
`endif
        r_lock    <= 1'b0;
        r_lgnt    <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        r_rsp_err <= 1'b0;
      end else begin
        if (w_accept) begin
`ifdef IOB_BUS_MERGE_FIXED_PRIO_EN
`else
          r_ptr  <= NB'((int'(w_sel) + 1) % N);
`endif
          r_lock <= 1'b0;
        end else if (w_stall) begin
          r_lock <= 1'b1;
          r_lgnt <= w_sel;
        end
        if (w_push) begin
          r_fifo[r_wptr] <= w_sel;
          r_wptr         <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - 1'b1;
        end
        if (w_stray) begin
          r_rsp_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_bus_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_bus_merge
// Brief    : Directed self-checking bench for iob_bus_merge (N=2, MAX_OUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_bus_merge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int N       = 2;
  localparam int SW      = DATA_W / 8;
  localparam int MAX_OUT = 4;
`ifdef IOB_BUS_MERGE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                clk_i;
  logic                cke_i;
  logic                rst_n_i;
  logic [N-1:0]        m_valid_i;
  logic [N*ADDR_W-1:0] m_addr_i;
  logic [N*DATA_W-1:0] m_wdata_i;
  logic [N*SW-1:0]     m_wstrb_i;
  logic [N*DATA_W-1:0] m_rdata_o;
  logic [N-1:0]        m_rvalid_o;
  logic [N-1:0]        m_ready_o;
  logic                s_valid_o;
  logic [ADDR_W-1:0]   s_addr_o;
  logic [DATA_W-1:0]   s_wdata_o;
  logic [SW-1:0]       s_wstrb_o;
  logic [DATA_W-1:0]   s_rdata_i;
  logic                s_rvalid_i;
  logic                s_ready_i;
  logic                rsp_err_o;

  int checks   = 0;
  int failures = 0;

  iob_bus_merge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N      (N),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i     (clk_i),
    .cke_i     (cke_i),
    .rst_n_i   (rst_n_i),
    .m_valid_i (m_valid_i),
    .m_addr_i  (m_addr_i),
    .m_wdata_i (m_wdata_i),
    .m_wstrb_i (m_wstrb_i),
    .m_rdata_o (m_rdata_o),
    .m_rvalid_o(m_rvalid_o),
    .m_ready_o (m_ready_o),
    .s_valid_o (s_valid_o),
    .s_addr_o  (s_addr_o),
    .s_wdata_o (s_wdata_o),
    .s_wstrb_o (s_wstrb_o),
    .s_rdata_i (s_rdata_i),
    .s_rvalid_i(s_rvalid_i),
    .s_ready_i (s_ready_i),
    .rsp_err_o (rsp_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic v, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [SW-1:0] s);
    m_valid_i[i]              = v;
    m_addr_i[i*ADDR_W +: ADDR_W] = a;
    m_wdata_i[i*DATA_W +: DATA_W] = d;
    m_wstrb_i[i*SW +: SW]     = s;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    m_valid_i  = '0;
    m_addr_i   = '0;
    m_wdata_i  = '0;
    m_wstrb_i  = '0;
    s_rdata_i  = '0;
    s_rvalid_i = 1'b0;
    s_ready_i  = 1'b1;
  endtask

  initial begin
    cke_i   = 1'b1;
    rst_n_i = 1'b0;
    idle();
    // Reset: outputs forced quiet even with live requests and responses.
    set_m(0, 1'b1, 32'h100, 32'h1, 4'hF);
    set_m(1, 1'b1, 32'h200, 32'h2, 4'hF);
    s_rvalid_i = 1'b1;
    @(negedge clk_i);
    chk("rst_s_valid", 64'(s_valid_o), 64'd0);
    chk("rst_m_ready", 64'(m_ready_o), 64'd0);
    chk("rst_m_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    tick();
    rst_n_i    = 1'b1;
    s_rvalid_i = 1'b0;

    // Continuous writes from both managers.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("rr_ready", 64'(m_ready_o), ((c % 2 == 1) && !FIXED) ? 64'd2 : 64'd1);
      chk("rr_addr", 64'(s_addr_o), ((c % 2 == 1) && !FIXED) ? 64'h200 : 64'h100);
      tick();
    end
    // Pointer now back at 0 in round-robin mode.

    // Stall: manager 1 holds the grant while manager 0 arrives.
    idle();
    s_ready_i = 1'b0;
    set_m(1, 1'b1, 32'h240, 32'h5, 4'h3);
    @(negedge clk_i);
    chk("stall_addr0", 64'(s_addr_o), 64'h240);
    chk("stall_valid0", 64'(s_valid_o), 64'd1);
    tick();
    set_m(0, 1'b1, 32'h140, 32'h6, 4'hF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk("stall_addr", 64'(s_addr_o), 64'h240);
      chk("stall_ready", 64'(m_ready_o), 64'd0);
      tick();
    end
    s_ready_i = 1'b1;
    @(negedge clk_i);
    chk("stall_acc_ready", 64'(m_ready_o), 64'd2);
    chk("stall_acc_addr", 64'(s_addr_o), 64'h240);
    tick();
    set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("after_stall_ready", 64'(m_ready_o), 64'd1);
    chk("after_stall_addr", 64'(s_addr_o), 64'h140);
    tick();

    // Reads from manager 0 then manager 1, responses returned in order.
    idle();
    set_m(0, 1'b1, 32'h10, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("rd0_ready", 64'(m_ready_o), 64'd1);
    chk("rd0_addr", 64'(s_addr_o), 64'h10);
    tick();
    idle();
    set_m(1, 1'b1, 32'h20, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("rd1_ready", 64'(m_ready_o), 64'd2);
    chk("rd1_addr", 64'(s_addr_o), 64'h20);
    tick();
    idle();
    tick();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hAAAA;
    @(negedge clk_i);
    chk("rsp0_rvalid", 64'(m_rvalid_o), 64'd1);
    chk("rsp0_rdata", 64'(m_rdata_o[0 +: DATA_W]), 64'hAAAA);
    tick();
    s_rdata_i = 32'hBBBB;
    @(negedge clk_i);
    chk("rsp1_rvalid", 64'(m_rvalid_o), 64'd2);
    chk("rsp1_rdata", 64'(m_rdata_o[DATA_W +: DATA_W]), 64'hBBBB);
    tick();
    idle();

    // Fill the read FIFO, then block, pop, and accept.
    set_m(0, 1'b1, 32'h30, 32'h0, 4'h0);
    for (int c = 0; c < MAX_OUT; c++) begin
      @(negedge clk_i);
      chk("fill_ready", 64'(m_ready_o), 64'd1);
      tick();
    end
    @(negedge clk_i);
    chk("full_ready", 64'(m_ready_o), 64'd0);
    chk("full_s_valid", 64'(s_valid_o), 64'd0);
    tick();
    s_rvalid_i = 1'b1;
    @(negedge clk_i);
    chk("full_pop_rvalid", 64'(m_rvalid_o), 64'd1);
    chk("full_pop_ready", 64'(m_ready_o), 64'd0);
    tick();
    s_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("after_pop_ready", 64'(m_ready_o), 64'd1);
    chk("after_pop_s_valid", 64'(s_valid_o), 64'd1);
    tick();
    set_m(0, 1'b1, 32'h34, 32'h77, 4'hF);
    @(negedge clk_i);
    chk("full_write_ready", 64'(m_ready_o), 64'd1);
    chk("full_write_valid", 64'(s_valid_o), 64'd1);
    tick();
    idle();

    // Reset with reads outstanding, then a stray response.
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    s_rvalid_i = 1'b1;
    @(negedge clk_i);
    chk("stray_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("stray_err_pre", 64'(rsp_err_o), 64'd0);
    tick();
    s_rvalid_i = 1'b0;
    set_m(0, 1'b1, 32'h100, 32'h1, 4'hF);
    set_m(1, 1'b1, 32'h200, 32'h2, 4'hF);
    @(negedge clk_i);
    chk("stray_err", 64'(rsp_err_o), 64'd1);
    chk("post_rst_ptr", 64'(m_ready_o), 64'd1);
    // Clock enable low: the accept does not advance the pointer.
    cke_i = 1'b0;
    tick();
    @(negedge clk_i);
    chk("cke_freeze_ready", 64'(m_ready_o), 64'd1);
    cke_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("cke_resume_ready", 64'(m_ready_o), FIXED ? 64'd1 : 64'd2);
    chk("err_sticky", 64'(rsp_err_o), 64'd1);
    tick();
    idle();
    rst_n_i = 1'b0;
    tick();
    @(negedge clk_i);
    chk("err_cleared", 64'(rsp_err_o), 64'd0);
    rst_n_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
